// File: rtl/ddr_ui_bridge_pkg.sv
// Shared types and constants for the DDR3 UI bridge: FSM states, UI command
// codes and the beat-to-slice index helper.
package ddr_ui_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    RESP  = 3'd4
  } state_t;

  localparam logic [2:0] UI_CMD_WRITE = 3'b000;
  localparam logic [2:0] UI_CMD_READ  = 3'b001;

  // Beat k on the UI maps to slice beats-1-k of the wide client word, so the
  // most-significant slice travels first.
  function automatic int unsigned beat_slice(input int unsigned k, input int unsigned beats);
    return beats - 1 - k;
  endfunction

endpackage

// File: rtl/ddr_ui_bridge.sv
// Client request/response port to DDR3 controller UI bridge with burst
// serialisation. Define DDR_UI_TIMEOUT_EN to enable the read watchdog.
module ddr_ui_bridge
  import ddr_ui_pkg::*;
#(
  parameter int ADDR_W      = 27,
  parameter int BEAT_W      = 64,
  parameter int BEATS       = 2,
  parameter int ALIGN_BITS  = 3,
  parameter int TIMEOUT_CYC = 127
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [BEAT_W*BEATS-1:0]   req_wdata,
  input  logic [BEAT_W*BEATS/8-1:0] req_be,
  output logic                      rsp_valid,
  output logic [BEAT_W*BEATS-1:0]   rsp_rdata,
  output logic                      rsp_error,
  output logic                      busy,
  output logic [ADDR_W-1:0]         app_addr,
  output logic [2:0]                app_cmd,
  output logic                      app_en,
  input  logic                      app_rdy,
  output logic [BEAT_W-1:0]         app_wdf_data,
  output logic [BEAT_W/8-1:0]       app_wdf_mask,
  output logic                      app_wdf_wren,
  output logic                      app_wdf_end,
  input  logic                      app_wdf_rdy,
  input  logic [BEAT_W-1:0]         app_rd_data,
  input  logic                      app_rd_data_valid,
  input  logic                      app_rd_data_end
);

  localparam int DATA_W = BEAT_W * BEATS;
  localparam int BE_W   = DATA_W / 8;
  localparam int MASK_W = BEAT_W / 8;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'((1 << ALIGN_BITS) - 1));

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    beat_reg, beat_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [2:0]          cmd_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [BE_W-1:0]     be_reg;
  logic [DATA_W-1:0]   rbuf_reg, rbuf_next;
  logic [DATA_W-1:0]   rdata_reg;

  logic                accept;
  logic                rbeat_accept;
  logic                rd_last;
  logic                rd_timeout;
  logic                wr_last;
  int unsigned         cur_slice;
  logic [BEAT_W-1:0]   wbeat;
  logic [MASK_W-1:0]   wbe;

  assign accept       = req_valid && req_ready;
  assign rbeat_accept = (state_reg == RDATA) && app_rd_data_valid;
  assign rd_last      = app_rd_data_end || (beat_reg == LAST_BEAT);
  assign wr_last      = (state_reg == WDATA) && app_wdf_rdy && (beat_reg == LAST_BEAT);

  always_comb begin
    cur_slice = beat_slice(32'(beat_reg), BEATS);
    wbeat     = wdata_reg[cur_slice*BEAT_W +: BEAT_W];
    wbe       = be_reg[cur_slice*MASK_W +: MASK_W];
    rbuf_next = rbuf_reg;
    if (rbeat_accept) begin
      rbuf_next[cur_slice*BEAT_W +: BEAT_W] = app_rd_data;
    end
  end

`ifdef DDR_UI_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);
  // Timer reads 0 in the first cycle after a beat, so hitting TIMEOUT_CYC-2
  // places RESP exactly TIMEOUT_CYC cycles after the last beat.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 2);

  logic [TIMER_W-1:0] timer_reg;
  logic               err_reg;

  assign rd_timeout = (state_reg == RDATA) && !app_rd_data_valid && (timer_reg == TIMER_LAST);
  assign rsp_error  = (state_reg == RESP) && err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (state_reg == RDATA && !rbeat_accept) begin
        timer_reg <= timer_reg + TIMER_W'(1);
      end else begin
        timer_reg <= '0;
      end
      if (rd_timeout) begin
        err_reg <= 1'b1;
      end else if ((rbeat_accept && rd_last) || wr_last) begin
        err_reg <= 1'b0;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
  assign rd_timeout     = 1'b0;
  assign rsp_error      = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = CMD;
          beat_next  = '0;
        end
      end
      CMD: begin
        if (app_rdy) begin
          state_next = (cmd_reg == UI_CMD_WRITE) ? WDATA : RDATA;
          beat_next  = '0;
        end
      end
      WDATA: begin
        if (app_wdf_rdy) begin
          if (beat_reg == LAST_BEAT) begin
            state_next = RESP;
            beat_next  = '0;
          end else begin
            beat_next = beat_reg + CNT_W'(1);
          end
        end
      end
      RDATA: begin
        if (rbeat_accept) begin
          if (rd_last) begin
            state_next = RESP;
            beat_next  = '0;
          end else begin
            beat_next = beat_reg + CNT_W'(1);
          end
        end else if (rd_timeout) begin
          state_next = RESP;
          beat_next  = '0;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      addr_reg  <= '0;
      cmd_reg   <= UI_CMD_READ;
      wdata_reg <= '0;
      be_reg    <= '0;
      rbuf_reg  <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      rbuf_reg  <= rbuf_next;
      if (accept) begin
        addr_reg  <= req_addr & ALIGN_MASK;
        cmd_reg   <= req_write ? UI_CMD_WRITE : UI_CMD_READ;
        wdata_reg <= req_wdata;
        be_reg    <= req_be;
        rbuf_reg  <= '0;  // missing slices of a timed-out read read back as 0
      end
      if (rbeat_accept && rd_last) begin
        rdata_reg <= rbuf_next;
      end else if (rd_timeout) begin
        rdata_reg <= rbuf_reg;
      end
    end
  end

  assign req_ready    = (state_reg == IDLE) && !reset;
  assign busy         = (state_reg != IDLE);
  assign app_addr     = addr_reg;
  assign app_cmd      = cmd_reg;
  assign app_en       = (state_reg == CMD);
  assign app_wdf_wren = (state_reg == WDATA);
  assign app_wdf_end  = app_wdf_wren && (beat_reg == LAST_BEAT);
  assign app_wdf_data = app_wdf_wren ? wbeat : '0;
  assign app_wdf_mask = app_wdf_wren ? ~wbe : '0;
  assign rsp_valid    = (state_reg == RESP);
  assign rsp_rdata    = rdata_reg;

endmodule

// File: tb/tb_ddr_ui_bridge.sv
// Directed bench for ddr_ui_bridge (BEAT_W=64, BEATS=2, TIMEOUT_CYC=20).
module tb_ddr_ui_bridge;

  localparam int ADDR_W = 27;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 2;
  localparam int DW     = BEAT_W * BEATS;
  localparam int BEW    = DW / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DW-1:0]     req_wdata;
  logic [BEW-1:0]    req_be;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_error;
  logic              busy;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [BEAT_W-1:0] app_wdf_data;
  logic [7:0]        app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [BEAT_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;

  int checks = 0;
  int errors = 0;

  ddr_ui_bridge #(
    .ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS), .ALIGN_BITS(3), .TIMEOUT_CYC(20)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_beat(input logic [63:0] d, input logic v, input logic e);
    app_rd_data       = d;
    app_rd_data_valid = v;
    app_rd_data_end   = e;
  endtask

  logic [63:0] a64, b64;
  logic        saw_rsp;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    rd_beat(64'h0, 1'b0, 1'b0);
    a64 = {16{4'hA}};
    b64 = {16{4'h5}};
    tick(); tick();
    chk("rst_app_cmd", app_cmd, 3'b001);
    chk("rst_app_en", app_en, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 128'h0);
    reset = 1'b0;
    #1;
    chk("idle_req_ready", req_ready, 1'b1);

    // Basic read: address alignment and beat ordering
    req_valid = 1'b1; req_write = 1'b0; req_addr = 27'h000012F;
    tick();
    req_valid = 1'b0;
    chk("rd_app_en", app_en, 1'b1);
    chk("rd_app_addr", app_addr, 27'h0000128);
    chk("rd_app_cmd", app_cmd, 3'b001);
    chk("rd_busy_ready", {busy, req_ready}, 2'b10);
    tick();
    chk("rd_en_drop", app_en, 1'b0);
    rd_beat(a64, 1'b1, 1'b0);
    tick();
    rd_beat(b64, 1'b1, 1'b1);
    tick();
    rd_beat(64'h0, 1'b0, 1'b0);
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rsp_error", rsp_error, 1'b0);
    chk("rd_rsp_rdata", rsp_rdata, {a64, b64});
    tick();
    chk("rd_rsp_pulse", rsp_valid, 1'b0);
    chk("rd_rdata_hold", rsp_rdata, {a64, b64});
    $display("read  addr=%h rdata=%h", 27'h12F, rsp_rdata);

    // Write with byte enables, minimum latency
    req_valid = 1'b1; req_write = 1'b1; req_addr = 27'h0000040;
    req_wdata = {{16{4'h1}}, {16{4'h2}}}; req_be = 16'hF0FF;
    tick();
    req_valid = 1'b0;
    chk("wr_t1_en_cmd", {app_en, app_cmd}, 4'b1000);
    tick();
    chk("wr_b0_strobes", {app_wdf_wren, app_wdf_end}, 2'b10);
    chk("wr_b0_data", app_wdf_data, {16{4'h1}});
    chk("wr_b0_mask", app_wdf_mask, 8'h0F);
    tick();
    chk("wr_b1_strobes", {app_wdf_wren, app_wdf_end}, 2'b11);
    chk("wr_b1_data", app_wdf_data, {16{4'h2}});
    chk("wr_b1_mask", app_wdf_mask, 8'h00);
    tick();
    chk("wr_t4_rsp", {rsp_valid, app_wdf_wren}, 2'b10);
    chk("wr_rdata_kept", rsp_rdata, {a64, b64});
    tick();
    chk("wr_idle", {busy, req_ready}, 2'b01);
    $display("write addr=%h wdata=%h be=%h", 27'h40, req_wdata, req_be);

    // Stalled command and write-data handshakes
    req_valid = 1'b1; req_write = 1'b1; req_addr = 27'h1234567;
    req_wdata = {64'hAAAA_BBBB_CCCC_DDDD, 64'h0123_4567_89AB_CDEF}; req_be = 16'h0F01;
    app_rdy = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_en_addr", {app_en, app_wdf_wren, app_addr}, {2'b10, 27'h1234560});
      if (i < 4) tick();
    end
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b0;
    tick();
    chk("stall_b0", {app_wdf_wren, app_wdf_end, app_wdf_mask, app_wdf_data}, {2'b10, 8'hF0, 64'hAAAA_BBBB_CCCC_DDDD});
    tick();
    chk("stall_b0_held", {app_wdf_wren, app_wdf_end, app_wdf_data}, {2'b10, 64'hAAAA_BBBB_CCCC_DDDD});
    app_wdf_rdy = 1'b1;
    tick();
    app_wdf_rdy = 1'b0;
    chk("stall_b1", {app_wdf_wren, app_wdf_end, app_wdf_mask, app_wdf_data}, {2'b11, 8'hFE, 64'h0123_4567_89AB_CDEF});
    tick();
    chk("stall_b1_held", {app_wdf_wren, app_wdf_end, app_wdf_data, rsp_valid}, {2'b11, 64'h0123_4567_89AB_CDEF, 1'b0});
    app_wdf_rdy = 1'b1;
    tick();
    chk("stall_rsp", {rsp_valid, app_wdf_wren}, 2'b10);
    tick();
    $display("write addr=%h stalled, complete", 27'h1234567);

    // Stray beat while idle, then back-to-back reads
    rd_beat(64'hDEAD_DEAD_DEAD_DEAD, 1'b1, 1'b1);
    tick();
    rd_beat(64'h0, 1'b0, 1'b0);
    chk("stray_idle", {busy, req_ready, rsp_valid}, 3'b010);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 27'h0000040;
    tick();
    req_addr = 27'h00001FF;
    chk("b2b_r1_cmd", {app_en, req_ready, app_addr}, {2'b10, 27'h0000040});
    tick();
    chk("b2b_r1_addr_stable", {req_ready, app_addr}, {1'b0, 27'h0000040});
    rd_beat(64'h0123_0123_0123_0123, 1'b1, 1'b0);
    tick();
    rd_beat(64'h89AB_89AB_89AB_89AB, 1'b1, 1'b1);
    tick();
    rd_beat(64'h0, 1'b0, 1'b0);
    chk("b2b_r1_rsp", {rsp_valid, req_ready, rsp_rdata},
        {2'b10, 64'h0123_0123_0123_0123, 64'h89AB_89AB_89AB_89AB});
    tick();
    chk("b2b_idle_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    chk("b2b_r2_cmd", {app_en, app_addr}, {1'b1, 27'h00001F8});
    tick();
    rd_beat(64'hCAFE_CAFE_CAFE_CAFE, 1'b1, 1'b0);
    tick();
    rd_beat(64'hF00D_F00D_F00D_F00D, 1'b1, 1'b0);
    tick();
    rd_beat(64'h0, 1'b0, 1'b0);
    chk("b2b_r2_rsp", {rsp_valid, rsp_rdata},
        {1'b1, 64'hCAFE_CAFE_CAFE_CAFE, 64'hF00D_F00D_F00D_F00D});
    tick();
    $display("read  addr=%h rdata=%h", 27'h1F8, rsp_rdata);

    // Reset in the middle of a write burst
    req_valid = 1'b1; req_write = 1'b1; req_addr = 27'h0000100;
    req_wdata = {128{1'b1}}; req_be = 16'hFFFF;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_b0", app_wdf_wren, 1'b1);
    tick();
    chk("mid_b1", app_wdf_end, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_strobes", {app_en, app_wdf_wren, app_wdf_end, rsp_valid, busy}, 5'b0);
    chk("mid_rst_ready", req_ready, 1'b1);
    chk("mid_rst_cmd_addr", {app_cmd, app_addr, rsp_rdata}, {3'b001, 27'h0, 128'h0});
    req_valid = 1'b1; req_write = 1'b0; req_addr = 27'h0000008;
    tick();
    req_valid = 1'b0;
    tick();
    rd_beat(64'h7777_7777_7777_7777, 1'b1, 1'b0);
    tick();
    rd_beat(64'h8888_8888_8888_8888, 1'b1, 1'b1);
    tick();
    rd_beat(64'h0, 1'b0, 1'b0);
    chk("post_rst_read", {rsp_valid, rsp_error, rsp_rdata},
        {2'b10, 64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888});
    tick();
    $display("read  addr=%h rdata=%h after reset", 27'h8, rsp_rdata);

    // Read that only ever returns its first beat
    req_valid = 1'b1; req_write = 1'b0; req_addr = 27'h0000200;
    tick();
    req_valid = 1'b0;
    tick();
    rd_beat(64'h4444_4444_4444_4444, 1'b1, 1'b0);
    tick();
    rd_beat(64'h0, 1'b0, 1'b0);
`ifdef DDR_UI_TIMEOUT_EN
    saw_rsp = rsp_valid;
    for (int i = 1; i < 19; i++) begin
      tick();
      saw_rsp = saw_rsp | rsp_valid;
    end
    chk("to_no_early_rsp", saw_rsp, 1'b0);
    tick();
    chk("to_rsp", {rsp_valid, rsp_error, rsp_rdata}, {2'b11, 64'h4444_4444_4444_4444, 64'h0});
    tick();
    chk("to_idle", {busy, rsp_valid, rsp_error}, 3'b000);
    rd_beat(64'h9999_9999_9999_9999, 1'b1, 1'b1);
    tick();
    rd_beat(64'h0, 1'b0, 1'b0);
    chk("to_late_beat", {busy, rsp_valid, rsp_rdata}, {2'b00, 64'h4444_4444_4444_4444, 64'h0});
    $display("read  addr=%h timed out rdata=%h", 27'h200, rsp_rdata);
`else
    saw_rsp = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      saw_rsp = saw_rsp | rsp_valid;
    end
    chk("nto_no_rsp", saw_rsp, 1'b0);
    chk("nto_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("nto_recover", {busy, req_ready}, 2'b01);
    $display("read  addr=%h still waiting, recovered by reset", 27'h200);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
